// File: rtl/seq_divider.sv
// seq_divider: iterative signed integer divider (restoring division).
// One quotient bit per clock, start/done handshake, truncation toward zero
// (matches Verilog / and %). Divide-by-zero and most-negative / -1 are flagged.
// Optional build macro: SEQ_DIVIDER_EARLY_EXIT_EN -- when defined, operands with
// |a| < |b| skip the iterative phase (same results, shorter latency).
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_FIX    = 2'd2
    } state_t;

    // Magnitude of a signed value, one bit wider so -2^(WIDTH-1) is representable.
    function automatic logic [WIDTH:0] f_mag(input logic signed [WIDTH-1:0] v);
        logic signed [WIDTH:0] ext;
        ext = (WIDTH + 1)'(v);
        return (v < 0) ? -ext : ext;
    endfunction

    // Re-apply a sign to an unsigned magnitude; wraps modulo 2^WIDTH.
    function automatic logic signed [WIDTH-1:0] f_apply_sign(input logic [WIDTH-1:0] mag,
                                                             input logic             neg);
        return neg ? -$signed(mag) : $signed(mag);
    endfunction

    state_t r_state;
    state_t w_state_next;

    // Iteration state: partial remainder, dividend/quotient shift register, divisor.
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH:0]   r_dvs;
    logic [CW-1:0]    r_cnt;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_zero;
    logic             r_ovf;

    logic [WIDTH:0]   w_a_mag;
    logic [WIDTH:0]   w_b_mag;
    logic             w_b_zero;
    logic             w_ovf;
    logic             w_accept;
    logic             w_early;
    logic             w_short;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_fit;
    logic             w_unused;

    assign w_a_mag  = f_mag($signed(a));
    assign w_b_mag  = f_mag($signed(b));
    assign w_b_zero = (b == '0);
    assign w_ovf    = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    assign w_accept = (r_state == S_IDLE) && start;

`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
    assign w_early = !w_b_zero && (w_a_mag < w_b_mag);
`else
    assign w_early = 1'b0;
`endif

    // Short path: skip iteration, result comes straight from the loaded remainder.
    assign w_short = w_b_zero || w_early;

    // Shift {remainder, dividend} left one place and trial-subtract the divisor.
    assign w_shift = {r_rem, r_dvd[WIDTH-1]};
    assign w_trial = {1'b0, w_shift} - {1'b0, r_dvs};
    assign w_fit   = ~w_trial[WIDTH+1];

    // The partial remainder is always below the divisor (<= 2^(WIDTH-1)), so the
    // upper bits of the trial difference and of |a| never carry information here.
    assign w_unused = w_trial[WIDTH] ^ w_a_mag[WIDTH];

    assign busy = (r_state != S_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = w_short ? S_FIX : S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                if (r_cnt == CW'(1)) begin
                    w_state_next = S_FIX;
                end
            end
            S_FIX: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand capture on accept, then one restoring-division step per DIVIDE cycle.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
            r_sign_r <= a[WIDTH-1];
            r_dvs    <= w_b_mag;
            r_zero   <= w_b_zero;
            r_ovf    <= w_ovf;
            r_cnt    <= CW'(WIDTH);
            if (w_short) begin
                r_rem <= w_a_mag[WIDTH-1:0];
                r_dvd <= '0;
            end else begin
                r_rem <= '0;
                r_dvd <= w_a_mag[WIDTH-1:0];
            end
        end else if (r_state == S_DIVIDE) begin
            r_rem <= w_fit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_dvd <= {r_dvd[WIDTH-2:0], w_fit};
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Result registers: sign fix-up in FIX, held until the next completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= (r_state == S_FIX);
            if (r_state == S_FIX) begin
                quotient    <= r_zero ? '1 : f_apply_sign(r_dvd, r_sign_q);
                remainder   <= f_apply_sign(r_rem, r_sign_r);
                div_by_zero <= r_zero;
                overflow    <= r_ovf;
            end
        end
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative signed integer divider for the expression solver datapath. It performs the inverse of the ALU multiply path.
- Takes a WIDTH-bit signed dividend and divisor and produces quotient and remainder using restoring division, one quotient bit per clock.
- Start/done handshake allows the solver control to issue divides alongside ALU add/multiply operations.

Parameters:
WIDTH, 16, operand/result width in bits (signed two's complement)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  signed dividend; sampled on accepted start
b  input  WIDTH  signed divisor; sampled on accepted start
busy  output  1  high while a divide is in progress (state != IDLE)
done  output  1  one-cycle pulse when quotient/remainder/flags are valid
quotient  output  WIDTH  signed quotient
remainder  output  WIDTH  signed remainder
div_by_zero  output  1  last completed operation had b == 0
overflow  output  1  last completed operation was most-negative / -1

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset (any state, including mid-divide):
  - state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0.
  - The in-flight operation is discarded; no done is issued for it.
- States: IDLE, DIVIDE, FIX.
- IDLE, start=1 at edge k:
  - Latch the signs of a and b, then |a| into the dividend shift register and |b| into the divisor register.
  - Magnitudes are WIDTH+1 bits internally, so |-2^(WIDTH-1)| is representable.
  - Clear the partial remainder, set the bit counter to WIDTH, go to DIVIDE, busy=1.
- IDLE, start=1 with b==0:
  - Go directly to FIX with the zero flag set.
- DIVIDE, each edge:
  - Shift {partial remainder, dividend} left by 1.
  - Trial subtract the divisor. If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set LSB to 0.
  - Decrement the counter. When the counter reaches 0 after this edge, go to FIX.
- FIX, one edge:
  - Apply signs: the quotient is negated if sign(a) != sign(b); the remainder takes the sign of a. This is truncation toward zero, matching Verilog / and %.
  - Register quotient, remainder and flags; done=1 for exactly this one cycle; busy=0; go to IDLE.
- Latency:
  - Normal: start accepted at edge k, done high in the cycle following edge k+WIDTH+1 (17 cycles for WIDTH=16).
  - Divide by zero: done after edge k+1.
- Divide by zero: quotient = all ones (-1), remainder = a, div_by_zero=1, overflow=0.
- Overflow: a = -2^(WIDTH-1), b = -1 gives quotient = -2^(WIDTH-1) (wrapped), remainder = 0, overflow=1, normal latency.
- Other cases: div_by_zero=0 and overflow=0.
- Output hold:
  - quotient, remainder and flags hold their values until the next done; they do not change when start is accepted.
  - done returns to 0 the next cycle.
- start while busy (DIVIDE or FIX) is ignored, with no queuing.
- start is sampled in IDLE, so start=1 in the cycle where done=1 is accepted. Back-to-back throughput is one divide per WIDTH+2 cycles.
- a and b may change freely after the accepting edge.

Optional Feature:
SEQ_DIVIDER_EARLY_EXIT_EN
- Defined: in IDLE, an accepted start with b != 0 and |a| < |b| skips DIVIDE and goes straight to FIX. Results are quotient=0, remainder=a, done after edge k+1.
- Not defined: such operands take the full WIDTH+1 cycle path with identical results.
- Results are identical in both builds; only latency differs.

Test Plan:
- Latency and basic result: a=100, b=7, start at edge k -> done only in cycle after edge k+17, quotient=14, remainder=2, both flags 0, busy low that cycle.
- Sign combinations: a=-100, b=7 -> q=-14, r=-2. a=100, b=-7 -> q=-14, r=2. a=-100, b=-7 -> q=14, r=-2.
- Overflow: a=-32768, b=-1 -> q=-32768 (16'h8000), r=0, overflow=1, latency 17.
- Divide by zero: a=5, b=0 -> done after edge k+1, q=16'hFFFF, r=5, div_by_zero=1. The next normal divide clears div_by_zero at its done.
- start ignored while busy: start a=50, b=3; pulse start with a=9, b=9 during DIVIDE -> single done, q=16, r=2. Then start in the done cycle with a=9, b=9 -> accepted, q=1, r=0 after 17 cycles.
- Reset mid-operation: assert rst 5 cycles into a divide -> all outputs 0 next cycle and no done issued. The next start with a=-7, b=2 gives q=-3, r=-1. With SEQ_DIVIDER_EARLY_EXIT_EN, a=3, b=10 -> done after edge k+1, q=0, r=3.
